// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_pkg
// Purpose  : Shared definitions for the clock divider controller: controller
//            state encoding, default counter width and minimum legal divisor.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

  localparam int c_CNT_W_DEFAULT = 20;
  localparam int c_MIN_DIV       = 2;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/clk_div_core.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_core
// Purpose  : Half-period counter and divided-clock toggle. Counts 1..H while
//            i_run is high and toggles o_clk each time the count reaches H.
// Ports    : i_clk, i_rst    - clock, asynchronous active-high reset
//            i_load          - restart: count back to 1, o_clk forced low
//            i_run           - advance the counter this cycle
//            i_half          - half period H (>= 1)
//            o_at_half       - count currently equals H (boundary cycle)
//            o_clk           - registered divided clock
//            o_tick          - one-cycle pulse in the first high cycle
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int P_CNT_W = c_CNT_W_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_run,
  input  logic [P_CNT_W-1:0] i_half,
  output logic               o_at_half,
  output logic               o_clk,
  output logic               o_tick
);

  logic [P_CNT_W-1:0] r_cnt;
  logic               r_clk;
  logic               r_tick;

  assign o_at_half = (r_cnt == i_half);
  assign o_clk     = r_clk;
  assign o_tick    = r_tick;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= P_CNT_W'(1);
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (i_load) begin
        r_cnt <= P_CNT_W'(1);
        r_clk <= 1'b0;
      end else if (i_run) begin
        if (o_at_half) begin
          r_cnt  <= P_CNT_W'(1);
          r_clk  <= ~r_clk;
          // Tick only on the 0->1 toggle.
          r_tick <= ~r_clk;
        end else begin
          r_cnt <= r_cnt + P_CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_ctrl
// Purpose  : Run/stop controller for a programmable clock divider. Divisor
//            changes while running are held pending and applied only at the
//            end of a full period; stopping never truncates a high phase.
// Ports    : i_clk, i_rst    - clock, asynchronous active-high reset
//            i_enable        - level request to run the divided clock
//            i_cfg_valid     - new divisor offered
//            i_cfg_div       - offered divisor (unsigned)
//            o_cfg_ready     - divisor can be accepted (STOP/RUN)
//            o_cfg_err       - one-cycle pulse: divisor < 2 rejected
//            o_clk           - registered divided clock
//            o_tick          - pulse in the cycle o_clk rises
//            o_running       - high in RUN and PEND
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int P_CNT_W     = c_CNT_W_DEFAULT,
  parameter int P_DIV_RESET = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_cfg_valid,
  input  logic [P_CNT_W-1:0] i_cfg_div,
  output logic               o_cfg_ready,
  output logic               o_cfg_err,
  output logic               o_clk,
  output logic               o_tick,
  output logic               o_running
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [P_CNT_W-1:0] r_div;
  logic [P_CNT_W-1:0] r_pend;
  logic               r_err;

  logic [P_CNT_W-1:0] w_half;
  logic [P_CNT_W-1:0] w_div_src;
  logic               w_load_div;
  logic               w_store_pend;
  logic               w_core_load;
  logic               w_core_run;
  logic               w_at_half;
  logic               w_oclk;
  logic               w_fall;
  logic               w_hs;
  logic               w_legal;
  logic               w_hs_ok;

  // Odd divisors round down: H = floor(div/2).
  assign w_half  = {1'b0, r_div[P_CNT_W-1:1]};
  assign w_fall  = w_at_half & w_oclk;
  assign w_hs    = i_cfg_valid & o_cfg_ready;
  assign w_legal = (i_cfg_div >= P_CNT_W'(c_MIN_DIV));
  assign w_hs_ok = w_hs & w_legal;

  assign o_cfg_ready = (r_state != ST_PEND);
  assign o_running   = (r_state != ST_STOP);
  assign o_cfg_err   = r_err;
  assign o_clk       = w_oclk;

  always_comb begin
    w_state_nxt  = r_state;
    w_load_div   = 1'b0;
    w_div_src    = i_cfg_div;
    w_store_pend = 1'b0;
    w_core_load  = 1'b0;
    w_core_run   = 1'b0;
    case (r_state)
      ST_STOP: begin
        w_core_load = 1'b1;
        w_load_div  = w_hs_ok;
        if (i_enable) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN, ST_PEND: begin
        // Stop immediately from a low phase; from a high phase only at the
        // 1->0 boundary so the high phase is never shortened.
        if (!i_enable && (!w_oclk || w_fall)) begin
          w_state_nxt = ST_STOP;
          w_core_load = ~w_oclk;
          w_core_run  = w_oclk;
          // A pending divisor (or one accepted in this very cycle) is not
          // lost by stopping.
          w_load_div  = (r_state == ST_PEND) | w_hs_ok;
          if (r_state == ST_PEND) begin
            w_div_src = r_pend;
          end
        end else begin
          w_core_run = 1'b1;
          if (w_fall && (r_state == ST_PEND)) begin
            w_load_div  = 1'b1;
            w_div_src   = r_pend;
            w_state_nxt = ST_RUN;
          end else if ((r_state == ST_RUN) && w_hs_ok) begin
            w_store_pend = 1'b1;
            w_state_nxt  = ST_PEND;
          end
        end
      end
      default: begin
        w_core_load = 1'b1;
        w_state_nxt = ST_STOP;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_STOP;
      r_div   <= P_CNT_W'(P_DIV_RESET);
      r_pend  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_hs & ~w_legal;
      if (w_load_div) begin
        r_div <= w_div_src;
      end
      if (w_store_pend) begin
        r_pend <= i_cfg_div;
      end
    end
  end

  clk_div_core #(
    .P_CNT_W (P_CNT_W)
  ) u_core (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_core_load),
    .i_run     (w_core_run),
    .i_half    (w_half),
    .o_at_half (w_at_half),
    .o_clk     (w_oclk),
    .o_tick    (o_tick)
  );

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_ctrl
// Purpose  : Self-checking bench for clk_div_ctrl. A phase-based model
//            (cycles since phase origin, current/pending divisor) predicts
//            every output each cycle; directed scenarios add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_ctrl;

  localparam int W = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic         cv  = 1'b0;
  logic [W-1:0] cd  = '0;
  logic         o_ready, o_err, o_clk_w, o_tick, o_run;

  clk_div_ctrl #(
    .P_CNT_W     (W),
    .P_DIV_RESET (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_enable    (en),
    .i_cfg_valid (cv),
    .i_cfg_div   (cd),
    .o_cfg_ready (o_ready),
    .o_cfg_err   (o_err),
    .o_clk       (o_clk_w),
    .o_tick      (o_tick),
    .o_running   (o_run)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // o_clk = (k / H) mod 2 while running, k counting cycles since the phase
  // origin (RUN entry or divisor apply); a rise happens at k mod 2H == H.
  bit m_run = 0;
  bit m_pv  = 0;
  bit m_err = 0;
  int m_k   = 0;
  int m_div = 4;
  int m_pend = 0;
  int m_h;
  bit m_cur, m_hs, m_ok, m_fall;

  function automatic bit exp_clk();
    if (!m_run) return 1'b0;
    return bit'((m_k / (m_div / 2)) % 2);
  endfunction

  function automatic bit exp_tick();
    if (!m_run) return 1'b0;
    return (m_k % m_div - (m_div % 2) == m_div / 2) || (m_k % (2 * (m_div / 2)) == m_div / 2);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_pv = 0; m_err = 0; m_k = 0; m_div = 4; m_pend = 0;
    end else begin
      m_h    = m_div / 2;
      m_cur  = exp_clk();
      m_hs   = cv && !m_pv;
      m_ok   = m_hs && (int'(cd) >= 2);
      m_err  = m_hs && (int'(cd) < 2);
      if (!m_run) begin
        if (m_ok) m_div = int'(cd);
        if (en) begin
          m_run = 1; m_k = 0;
        end
      end else begin
        m_fall = m_cur && ((m_k + 1) % m_h == 0);
        if (!en && (!m_cur || m_fall)) begin
          m_run = 0;
          if (m_pv) begin
            m_div = m_pend; m_pv = 0;
          end else if (m_ok) begin
            m_div = int'(cd);
          end
        end else if (m_fall && m_pv) begin
          m_div = m_pend; m_pv = 0; m_k = 0;
        end else begin
          m_k++;
          if (m_ok) begin
            m_pend = int'(cd); m_pv = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model", {27'd0, o_run, o_ready, o_err, o_tick, o_clk_w},
                 {27'd0, m_run, !m_pv, m_err, (m_run && (m_k % (2 * (m_div / 2)) == m_div / 2)), exp_clk()});
  end

  // ---------------- helpers ----------------
  task automatic measure(output int hi, output int per);
    int n;
    n = 0; hi = 0; per = 0;
    while (o_clk_w !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    while (o_clk_w !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    while (o_clk_w === 1'b1 && n < 400) begin @(negedge clk); hi++; n++; end
    per = hi;
    while (o_clk_w === 1'b0 && n < 400) begin @(negedge clk); per++; n++; end
    if (n >= 400) chk("measure_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_level(input logic lvl);
    int n;
    n = 0;
    while (o_clk_w !== lvl && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("wait_timeout", 32'(n), 32'd0);
  endtask

  task automatic offer(input int v);
    cv = 1'b1; cd = W'(v);
    @(negedge clk);
    cv = 1'b0; cd = '0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int c, hi, per;
    repeat (3) @(negedge clk);
    chk("reset_clk",     o_clk_w, 0);
    chk("reset_tick",    o_tick,  0);
    chk("reset_err",     o_err,   0);
    chk("reset_running", o_run,   0);
    chk("reset_ready",   o_ready, 1);

    // Default divisor 4.
    rst = 1'b0; en = 1'b1;
    @(negedge clk);
    chk("run_entry", o_run, 1);
    c = 0;
    while (o_clk_w === 1'b0 && c < 50) begin @(negedge clk); c++; end
    chk("first_rise_delay", 32'(c), 2);
    measure(hi, per);
    chk("div4_high", 32'(hi), 2);
    chk("div4_period", 32'(per), 4);
    c = 0;
    repeat (16) begin @(negedge clk); if (o_tick === 1'b1) c++; end
    chk("div4_ticks16", 32'(c), 4);

    // Illegal divisor 1.
    offer(1);
    chk("err_pulse", o_err, 1);
    @(negedge clk);
    chk("err_clear", o_err, 0);
    measure(hi, per);
    chk("after_err_period", 32'(per), 4);

    // Divisor 10 offered during high phase.
    wait_level(1'b1);
    offer(10);
    chk("pend_ready_low", o_ready, 0);
    measure(hi, per);
    chk("div10_high", 32'(hi), 5);
    chk("div10_period", 32'(per), 10);
    chk("ready_after_apply", o_ready, 1);

    // Short enable dropout during high phase: no gap.
    wait_level(1'b1);
    en = 1'b0; @(negedge clk); en = 1'b1;
    measure(hi, per);
    chk("glitch_period", 32'(per), 10);

    // Drop enable during low phase: stop next cycle.
    wait_level(1'b0);
    en = 1'b0;
    @(negedge clk);
    chk("low_stop", o_run, 0);
    en = 1'b1;

    // Drop enable one cycle after a rise: full high phase kept.
    wait_level(1'b0);
    wait_level(1'b1);
    @(negedge clk);
    en = 1'b0;
    hi = 2;
    c = 0;
    while (c < 50) begin
      @(negedge clk); c++;
      if (o_clk_w !== 1'b1) break;
      hi++;
    end
    chk("stop_high_len", 32'(hi), 5);
    chk("stop_running", o_run, 0);
    c = 0;
    repeat (20) begin @(negedge clk); if (o_tick === 1'b1) c++; end
    chk("stop_no_tick", 32'(c), 0);

    // Divisor 7 in STOP -> period 6.
    offer(7);
    en = 1'b1;
    measure(hi, per);
    chk("div7_high", 32'(hi), 3);
    chk("div7_period", 32'(per), 6);

    // Back to 4, then reset in the middle of PEND.
    offer(4);
    measure(hi, per);
    measure(hi, per);
    chk("back_div4_period", 32'(per), 4);
    wait_level(1'b1);
    offer(10);
    chk("pend_before_rst", o_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_clk",     o_clk_w, 0);
    chk("rst_tick",    o_tick,  0);
    chk("rst_err",     o_err,   0);
    chk("rst_running", o_run,   0);
    chk("rst_ready",   o_ready, 1);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; en = 1'b1;
    measure(hi, per);
    chk("post_rst_high", 32'(hi), 2);
    chk("post_rst_period", 32'(per), 4);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
